// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one single-port regfile between ports A and B.
// Each transaction is a req/ack handshake. All outputs come from registers.
module regfile_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          req_a,
    input  logic          wr_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    output logic          ack_a,
    output logic [DW-1:0] rdata_a,
    input  logic          req_b,
    input  logic          wr_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          ack_b,
    output logic [DW-1:0] rdata_b,
    output logic          rf_we_,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_din,
    input  logic [DW-1:0] rf_dout,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPT,
        DONE
    } state_t;

    state_t state;
    logic   win_b;
    logic   last_b;
    logic   pick_b;
    logic   pick_wr;

    // B wins when it is the only requester, or on contention when A went last
    assign pick_b  = req_b & (~req_a | ~last_b);
    assign pick_wr = pick_b ? wr_b : wr_a;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state   <= IDLE;
            rf_we_  <= 1'b1;
            rf_addr <= '0;
            rf_din  <= '0;
            ack_a   <= 1'b0;
            ack_b   <= 1'b0;
            rdata_a <= '0;
            rdata_b <= '0;
            busy    <= 1'b0;
            win_b   <= 1'b0;
            last_b  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_a | req_b) begin
                        win_b   <= pick_b;
                        last_b  <= pick_b;
                        rf_addr <= pick_b ? addr_b : addr_a;
                        rf_din  <= pick_b ? wdata_b : wdata_a;
                        rf_we_  <= ~pick_wr;
                        busy    <= 1'b1;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // the write strobe commits on this edge
                    if (!rf_we_) begin
                        rf_we_ <= 1'b1;
                        ack_a  <= ~win_b;
                        ack_b  <= win_b;
                        state  <= DONE;
                    end else begin
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    if (win_b) begin
                        rdata_b <= rf_dout;
                    end else begin
                        rdata_a <= rf_dout;
                    end
                    ack_a <= ~win_b;
                    ack_b <= win_b;
                    state <= DONE;
                end
                DONE: begin
                    ack_a <= 1'b0;
                    ack_b <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural regfile model.
// Checks latency, round-robin order, reset abort and read-data hold.
module tb_regfile_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_ = 1'b0;
    logic          req_a = 1'b0;
    logic          wr_a = 1'b0;
    logic [AW-1:0] addr_a = '0;
    logic [DW-1:0] wdata_a = '0;
    logic          ack_a;
    logic [DW-1:0] rdata_a;
    logic          req_b = 1'b0;
    logic          wr_b = 1'b0;
    logic [AW-1:0] addr_b = '0;
    logic [DW-1:0] wdata_b = '0;
    logic          ack_b;
    logic [DW-1:0] rdata_b;
    logic          rf_we_;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_din;
    logic [DW-1:0] rf_dout;
    logic          busy;

    logic [DW-1:0] mem [32] = '{default: '0};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rf_we_) mem[rf_addr] <= rf_din;
    end
    assign rf_dout = mem[rf_addr];

    regfile_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset_(reset_),
        .req_a(req_a), .wr_a(wr_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .ack_a(ack_a), .rdata_a(rdata_a),
        .req_b(req_b), .wr_b(wr_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .ack_b(ack_b), .rdata_b(rdata_b),
        .rf_we_(rf_we_), .rf_addr(rf_addr), .rf_din(rf_din),
        .rf_dout(rf_dout), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_) chk("ack_excl", {31'd0, ack_a & ack_b}, 32'd0);
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_we"}, {31'd0, rf_we_}, 32'd1);
        chk({tag, "_addr"}, {27'd0, rf_addr}, 32'd0);
        chk({tag, "_din"}, rf_din, 32'd0);
        chk({tag, "_acka"}, {31'd0, ack_a}, 32'd0);
        chk({tag, "_ackb"}, {31'd0, ack_b}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_rda"}, rdata_a, 32'd0);
        chk({tag, "_rdb"}, rdata_b, 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_ = 1'b0;
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        reset_ = 1'b1;
    endtask

    // single transaction on one port; called at a negedge with FSM idle
    task automatic xact(input bit pb, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                        input string tag);
        int lat;
        bit got;
        if (pb) begin
            req_b = 1'b1; wr_b = wr; addr_b = a; wdata_b = d;
        end else begin
            req_a = 1'b1; wr_a = wr; addr_a = a; wdata_a = d;
        end
        got = 1'b0;
        lat = 0;
        for (int n = 1; n <= 8 && !got; n++) begin
            @(negedge clk);
            if (n == 1) begin
                chk({tag, "_we_acc"}, {31'd0, rf_we_}, {31'd0, !wr});
                chk({tag, "_addr"}, {27'd0, rf_addr}, {27'd0, a});
                chk({tag, "_busy_acc"}, {31'd0, busy}, 32'd1);
            end
            if (n == 2) begin
                chk({tag, "_we_off"}, {31'd0, rf_we_}, 32'd1);
                chk({tag, "_busy2"}, {31'd0, busy}, 32'd1);
            end
            if (pb ? ack_b : ack_a) begin
                got = 1'b1;
                lat = n;
            end
        end
        chk({tag, "_lat"}, lat, wr ? 32'd2 : 32'd3);
        if (!wr) chk({tag, "_rdata"}, pb ? rdata_b : rdata_a, exp_rd);
        req_a = 1'b0;
        req_b = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_1cyc"}, {30'd0, ack_a, ack_b}, 32'd0);
        chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int nacks;
        int t_a;
        int t_b;
        bit exp_b;

        // reset state
        apply_reset();

        // basic write on A
        xact(1'b0, 1'b1, 5'd3, 32'h12345678, '0, "wrA1");
        chk("wrA1_mem", mem[3], 32'h12345678);

        // write on A then read back on B
        xact(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, '0, "wrA2");
        xact(1'b1, 1'b0, 5'd3, '0, 32'hDEADBEEF, "rdB");
        chk("rdB_rda_untouched", rdata_a, 32'd0);

        // continuous contention: last grant was B, so A goes first
        req_a = 1'b1; wr_a = 1'b1; addr_a = 5'd1; wdata_a = 32'hA1A1A1A1;
        req_b = 1'b1; wr_b = 1'b1; addr_b = 5'd2; wdata_b = 32'hB2B2B2B2;
        nacks = 0;
        exp_b = 1'b0;
        for (int n = 1; n <= 20 && nacks < 4; n++) begin
            @(negedge clk);
            if (ack_a | ack_b) begin
                chk("rr_order", {31'd0, ack_b}, {31'd0, exp_b});
                chk("rr_time", n, 2 + 3 * nacks);
                exp_b = !exp_b;
                nacks++;
                if (nacks == 4) begin
                    req_a = 1'b0;
                    req_b = 1'b0;
                end
            end
        end
        chk("rr_count", nacks, 4);
        @(negedge clk);
        chk("rr_ack_width", {30'd0, ack_a, ack_b}, 32'd0);

        // first contention after reset: A then B, both reads
        apply_reset();
        req_a = 1'b1; wr_a = 1'b0; addr_a = 5'd1;
        req_b = 1'b1; wr_b = 1'b0; addr_b = 5'd2;
        t_a = 0;
        t_b = 0;
        for (int n = 1; n <= 12 && t_b == 0; n++) begin
            @(negedge clk);
            if (ack_a) begin
                t_a = n;
                chk("cont_rda", rdata_a, 32'hA1A1A1A1);
                req_a = 1'b0;
            end
            if (ack_b) begin
                t_b = n;
                chk("cont_rdb", rdata_b, 32'hB2B2B2B2);
                req_b = 1'b0;
            end
        end
        chk("cont_ta", t_a, 3);
        chk("cont_tb", t_b, 7);
        @(negedge clk);

        // reset during ACCESS of a B write aborts it
        xact(1'b0, 1'b1, 5'd7, 32'h11111111, '0, "wr7");
        req_b = 1'b1; wr_b = 1'b1; addr_b = 5'd7; wdata_b = 32'h77777777;
        @(negedge clk);
        chk("abort_in_access", {31'd0, rf_we_}, 32'd0);
        reset_ = 1'b0;
        req_b = 1'b0;
        #1;
        check_reset_vals("abort");
        @(negedge clk);
        reset_ = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("abort_no_ackb", {31'd0, ack_b}, 32'd0);
        end
        xact(1'b0, 1'b0, 5'd7, '0, 32'h11111111, "rd7");

        // read data held across a following write
        xact(1'b0, 1'b1, 5'd9, 32'hCAFEF00D, '0, "wr9");
        xact(1'b0, 1'b0, 5'd9, '0, 32'hCAFEF00D, "rd9");
        req_a = 1'b1; wr_a = 1'b1; addr_a = 5'd9; wdata_a = 32'h00000000;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            chk("hold_rda", rdata_a, 32'hCAFEF00D);
            if (ack_a) req_a = 1'b0;
        end
        chk("hold_req_dropped", {31'd0, req_a}, 32'd0);
        xact(1'b0, 1'b0, 5'd9, '0, 32'h00000000, "rd9b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
